// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register: decodes ALU control, captures operands, detects hazards and forwards.
// Optional macro ID_EX_FORWARD_EN enables MEM/WB forwarding; without it RAW hazards stall instead.
module id_ex_operand_stage #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [5:0]          id_opcode,
    input  logic [5:0]          id_funct,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic [WIDTH-1:0]    id_rs_data,
    input  logic [WIDTH-1:0]    id_rt_data,
    input  logic [15:0]         id_imm,
    input  logic                ex_hold,
    input  logic                flush,
    input  logic                mem_valid,
    input  logic                mem_reg_write,
    input  logic [REG_BITS-1:0] mem_dest,
    input  logic [WIDTH-1:0]    mem_result,
    input  logic                wb_valid,
    input  logic                wb_reg_write,
    input  logic [REG_BITS-1:0] wb_dest,
    input  logic [WIDTH-1:0]    wb_result,
    output logic                id_stall,
    output logic                ex_valid,
    output logic [2:0]          ex_alu_control,
    output logic [WIDTH-1:0]    ex_a,
    output logic [WIDTH-1:0]    ex_b,
    output logic [WIDTH-1:0]    ex_store_data,
    output logic [REG_BITS-1:0] ex_dest,
    output logic                ex_reg_write,
    output logic                ex_mem_read,
    output logic                ex_mem_write,
    output logic                ex_branch
);

    localparam logic [2:0] AluAdd  = 3'd0;
    localparam logic [2:0] AluSub  = 3'd1;
    localparam logic [2:0] AluAnd  = 3'd2;
    localparam logic [2:0] AluNor  = 3'd3;
    localparam logic [2:0] AluOr   = 3'd4;
    localparam logic [2:0] AluXor  = 3'd5;
    localparam logic [2:0] AluSlt  = 3'd6;
    localparam logic [2:0] AluNone = 3'd7;

    typedef struct packed {
        logic                valid;
        logic [2:0]          alu_ctrl;
        logic [REG_BITS-1:0] rs;
        logic [REG_BITS-1:0] rt;
        logic [WIDTH-1:0]    rs_data;
        logic [WIDTH-1:0]    rt_data;
        logic [WIDTH-1:0]    imm;
        logic                use_imm;
        logic [REG_BITS-1:0] dest;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                branch;
    } ex_state_t;

    ex_state_t ex_q, ex_d, bubble, captured;

    logic [2:0]          dec_alu;
    logic                dec_sext;
    logic                dec_use_imm;
    logic                dec_rt_used;
    logic [REG_BITS-1:0] dec_dest;
    logic                dec_reg_write;
    logic                dec_mem_read;
    logic                dec_mem_write;
    logic                dec_branch;
    logic [WIDTH-1:0]    dec_imm_ext;

    always_comb begin
        dec_alu       = AluNone;
        dec_sext      = 1'b0;
        dec_use_imm   = 1'b1;
        dec_rt_used   = 1'b0;
        dec_dest      = '0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        unique case (id_opcode)
            6'h00: begin
                dec_use_imm = 1'b0;
                dec_rt_used = 1'b1;
                dec_dest    = id_rd;
                dec_reg_write = 1'b1;
                unique case (id_funct)
                    6'h20, 6'h21: dec_alu = AluAdd;
                    6'h22, 6'h23: dec_alu = AluSub;
                    6'h24:        dec_alu = AluAnd;
                    6'h27:        dec_alu = AluNor;
                    6'h25:        dec_alu = AluOr;
                    6'h26:        dec_alu = AluXor;
                    6'h2A:        dec_alu = AluSlt;
                    default: begin
                        dec_dest      = '0;
                        dec_reg_write = 1'b0;
                    end
                endcase
            end
            6'h08, 6'h09: begin
                dec_alu = AluAdd; dec_sext = 1'b1; dec_dest = id_rt; dec_reg_write = 1'b1;
            end
            6'h0A: begin
                dec_alu = AluSlt; dec_sext = 1'b1; dec_dest = id_rt; dec_reg_write = 1'b1;
            end
            6'h0C: begin dec_alu = AluAnd; dec_dest = id_rt; dec_reg_write = 1'b1; end
            6'h0D: begin dec_alu = AluOr;  dec_dest = id_rt; dec_reg_write = 1'b1; end
            6'h0E: begin dec_alu = AluXor; dec_dest = id_rt; dec_reg_write = 1'b1; end
            6'h23: begin
                dec_alu = AluAdd; dec_sext = 1'b1; dec_dest = id_rt;
                dec_reg_write = 1'b1; dec_mem_read = 1'b1;
            end
            6'h2B: begin
                dec_alu = AluAdd; dec_sext = 1'b1; dec_rt_used = 1'b1; dec_mem_write = 1'b1;
            end
            6'h04: begin
                dec_alu = AluSub; dec_use_imm = 1'b0; dec_rt_used = 1'b1; dec_branch = 1'b1;
            end
            default: ;
        endcase
    end

    assign dec_imm_ext = dec_sext ? {{(WIDTH-16){id_imm[15]}}, id_imm}
                                  : {{(WIDTH-16){1'b0}}, id_imm};

    always_comb begin
        bubble          = '0;
        bubble.alu_ctrl = AluNone;

        captured           = '0;
        captured.valid     = 1'b1;
        captured.alu_ctrl  = dec_alu;
        captured.rs        = id_rs;
        captured.rt        = id_rt;
        captured.rs_data   = id_rs_data;
        captured.rt_data   = id_rt_data;
        captured.imm       = dec_imm_ext;
        captured.use_imm   = dec_use_imm;
        captured.dest      = dec_dest;
        // Writes to $0 are architecturally discarded, so never advertise them downstream.
        captured.reg_write = dec_reg_write & (dec_dest != '0);
        captured.mem_read  = dec_mem_read;
        captured.mem_write = dec_mem_write;
        captured.branch    = dec_branch;
    end

    logic id_uses_ex_dest;
    logic mem_writes;
    logic load_use;
    logic data_stall;

    assign id_uses_ex_dest = (ex_q.dest == id_rs) | (dec_rt_used & (ex_q.dest == id_rt));
    assign mem_writes      = mem_valid & mem_reg_write & (mem_dest != '0);
    assign load_use        = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.dest != '0)
                           & id_uses_ex_dest;

    logic [WIDTH-1:0] fwd_rs;
    logic [WIDTH-1:0] fwd_rt;

`ifdef ID_EX_FORWARD_EN
    logic wb_writes;
    assign wb_writes  = wb_valid & wb_reg_write & (wb_dest != '0);
    assign data_stall = load_use;

    always_comb begin
        fwd_rs = ex_q.rs_data;
        fwd_rt = ex_q.rt_data;
        if (mem_writes && mem_dest == ex_q.rs) begin
            fwd_rs = mem_result;
        end else if (wb_writes && wb_dest == ex_q.rs) begin
            fwd_rs = wb_result;
        end
        if (mem_writes && mem_dest == ex_q.rt) begin
            fwd_rt = mem_result;
        end else if (wb_writes && wb_dest == ex_q.rt) begin
            fwd_rt = wb_result;
        end
    end
`else
    // WB hazards are covered by the register file's write-first bypass.
    logic raw_stall;
    logic unused_fwd_inputs;
    assign raw_stall = id_valid & (
        (ex_q.valid & ex_q.reg_write & (ex_q.dest != '0) & id_uses_ex_dest) |
        (mem_writes & ((mem_dest == id_rs) | (dec_rt_used & (mem_dest == id_rt)))));
    assign data_stall = load_use | raw_stall;
    assign unused_fwd_inputs = ^{wb_valid, wb_reg_write, wb_dest, wb_result, mem_result,
                                 ex_q.rs, ex_q.rt};

    always_comb begin
        fwd_rs = ex_q.rs_data;
        fwd_rt = ex_q.rt_data;
    end
`endif

    assign id_stall = data_stall | ex_hold;

    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = bubble;
        end else if (ex_hold) begin
            // Keep forwarded values: the producing WB entry may retire while EX is frozen.
            ex_d.rs_data = fwd_rs;
            ex_d.rt_data = fwd_rt;
        end else if (data_stall || !id_valid) begin
            ex_d = bubble;
        end else begin
            ex_d = captured;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q <= bubble;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid       = ex_q.valid;
    assign ex_alu_control = ex_q.alu_ctrl;
    assign ex_a           = fwd_rs;
    assign ex_b           = ex_q.use_imm ? ex_q.imm : fwd_rt;
    assign ex_store_data  = fwd_rt;
    assign ex_dest        = ex_q.dest;
    assign ex_reg_write   = ex_q.reg_write;
    assign ex_mem_read    = ex_q.mem_read;
    assign ex_mem_write   = ex_q.mem_write;
    assign ex_branch      = ex_q.branch;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: stimulus queues expected values tagged by cycle,
// a negedge monitor compares them; expectations follow ID_EX_FORWARD_EN when defined.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [5:0]  id_opcode, id_funct;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] id_rs_data, id_rt_data;
    logic [15:0] id_imm;
    logic        ex_hold, flush;
    logic        mem_valid, mem_reg_write;
    logic [4:0]  mem_dest;
    logic [31:0] mem_result;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_dest;
    logic [31:0] wb_result;
    logic        id_stall, ex_valid;
    logic [2:0]  ex_alu_control;
    logic [31:0] ex_a, ex_b, ex_store_data;
    logic [4:0]  ex_dest;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;

    id_ex_operand_stage #(.WIDTH(32), .REG_BITS(5)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_funct(id_funct), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .ex_hold(ex_hold), .flush(flush), .mem_valid(mem_valid),
        .mem_reg_write(mem_reg_write), .mem_dest(mem_dest), .mem_result(mem_result),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_dest(wb_dest),
        .wb_result(wb_result), .id_stall(id_stall), .ex_valid(ex_valid),
        .ex_alu_control(ex_alu_control), .ex_a(ex_a), .ex_b(ex_b),
        .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {KValid, KAlu, KA, KB, KSd, KDest, KRw, KMr, KMw, KBr, KStall} kind_t;
    typedef struct {
        int          cyc;
        string       name;
        kind_t       kind;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;
    logic [31:0] got;

    function automatic logic [31:0] sample(input kind_t k);
        logic [31:0] r;
        r = '0;
        case (k)
            KValid: r = 32'(ex_valid);
            KAlu:   r = 32'(ex_alu_control);
            KA:     r = ex_a;
            KB:     r = ex_b;
            KSd:    r = ex_store_data;
            KDest:  r = 32'(ex_dest);
            KRw:    r = 32'(ex_reg_write);
            KMr:    r = 32'(ex_mem_read);
            KMw:    r = 32'(ex_mem_write);
            KBr:    r = 32'(ex_branch);
            KStall: r = 32'(id_stall);
            default: r = 'x;
        endcase
        return r;
    endfunction

    // Monitor: compare every expectation due this cycle; a stale entry counts as a miss.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                got = sample(sb[i].kind);
                checks++;
                if (sb[i].cyc != cyc || got !== sb[i].val) begin
                    errors++;
                    $display("FAIL %s (cycle %0d): actual %h required %h",
                             sb[i].name, cyc, got, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL timeout: stimulus did not complete, %0d expectations pending",
                 sb.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic chk(input int off, input string name, input kind_t k, input logic [31:0] v);
        exp_t e;
        e.cyc  = cyc + off;
        e.name = name;
        e.kind = k;
        e.val  = v;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                            input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                            input logic [31:0] rsd, input logic [31:0] rtd,
                            input logic [15:0] imm);
        id_valid = v; id_opcode = op; id_funct = fn;
        id_rs = rs; id_rt = rt; id_rd = rd;
        id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    endtask

    task automatic set_mem(input logic v, input logic rw, input logic [4:0] d,
                           input logic [31:0] r);
        mem_valid = v; mem_reg_write = rw; mem_dest = d; mem_result = r;
    endtask

    task automatic set_wb(input logic v, input logic rw, input logic [4:0] d,
                          input logic [31:0] r);
        wb_valid = v; wb_reg_write = rw; wb_dest = d; wb_result = r;
    endtask

    initial begin
        reset = 1'b1; ex_hold = 1'b0; flush = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        set_mem(0, 0, 0, 0);
        set_wb(0, 0, 0, 0);
        step();
        step();
        checks++;
        if (ex_valid !== 1'b0 || ex_alu_control !== 3'd7 || ex_a !== 32'd0 ||
            ex_b !== 32'd0 || ex_store_data !== 32'd0 || id_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: actual valid=%b alu=%0d a=%h b=%h sd=%h stall=%b",
                     ex_valid, ex_alu_control, ex_a, ex_b, ex_store_data, id_stall);
        end
        chk(0, "rst_valid", KValid, 0);
        chk(0, "rst_alu", KAlu, 7);
        chk(0, "rst_a", KA, 0);
        chk(0, "rst_b", KB, 0);
        chk(0, "rst_sd", KSd, 0);
        chk(0, "rst_stall", KStall, 0);

        // ori $2,$0,0xF00F
        reset = 1'b0;
        drive_id(1, 6'h0D, 0, 0, 2, 0, 0, 0, 16'hF00F);
        chk(0, "ori_stall", KStall, 0);
        chk(1, "ori_valid", KValid, 1);
        chk(1, "ori_alu", KAlu, 4);
        chk(1, "ori_a", KA, 0);
        chk(1, "ori_b", KB, 32'h0000F00F);
        chk(1, "ori_dest", KDest, 2);
        chk(1, "ori_rw", KRw, 1);
        step();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        chk(0, "drain_valid", KValid, 0);

        // addi $3,$2,-1 with $2 pending in MEM (5) and WB (9)
        set_mem(1, 1, 2, 32'd5);
        set_wb(1, 1, 2, 32'd9);
        drive_id(1, 6'h08, 0, 2, 3, 0, 32'h77, 0, 16'hFFFF);
`ifdef ID_EX_FORWARD_EN
        chk(0, "addi_stall", KStall, 0);
        chk(1, "addi_a_mem", KA, 5);
        chk(1, "addi_b", KB, 32'hFFFFFFFF);
        chk(1, "addi_alu", KAlu, 0);
        chk(1, "addi_dest", KDest, 3);
        step();
        step();
        set_mem(0, 0, 0, 0);
        chk(0, "addi_a_wb", KA, 9);
`else
        chk(0, "addi_stall", KStall, 1);
        chk(1, "addi_bubble_valid", KValid, 0);
        chk(1, "addi_bubble_alu", KAlu, 7);
        step();
        set_mem(0, 0, 0, 0);
        set_wb(0, 0, 0, 0);
        chk(0, "addi_stall_clear", KStall, 0);
        chk(1, "addi_a", KA, 32'h77);
        chk(1, "addi_b", KB, 32'hFFFFFFFF);
        chk(1, "addi_alu", KAlu, 0);
        step();
`endif
        set_mem(0, 0, 0, 0);
        set_wb(0, 0, 0, 0);
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // lw $4,0($1) then add $5,$4,$1
        drive_id(1, 6'h23, 0, 1, 4, 0, 32'h100, 0, 16'h0000);
        chk(0, "lw_stall", KStall, 0);
        chk(1, "lw_mr", KMr, 1);
        chk(1, "lw_a", KA, 32'h100);
        chk(1, "lw_dest", KDest, 4);
        chk(1, "lw_rw", KRw, 1);
        step();
        drive_id(1, 6'h00, 6'h20, 4, 1, 5, 32'hDEAD, 32'h10, 16'h0000);
        chk(0, "lu_stall", KStall, 1);
        chk(1, "lu_bubble_valid", KValid, 0);
        chk(1, "lu_bubble_alu", KAlu, 7);
        step();
        set_mem(1, 1, 4, 32'h4444);
`ifdef ID_EX_FORWARD_EN
        chk(0, "lu_stall_clear", KStall, 0);
        chk(1, "lu_add_a", KA, 32'h4444);
        chk(1, "lu_add_b", KB, 32'h10);
        chk(1, "lu_add_alu", KAlu, 0);
        chk(1, "lu_add_dest", KDest, 5);
        step();
`else
        chk(0, "lu_raw_stall", KStall, 1);
        step();
        set_mem(0, 0, 0, 0);
        drive_id(1, 6'h00, 6'h20, 4, 1, 5, 32'h4444, 32'h10, 16'h0000);
        chk(0, "lu_stall_clear", KStall, 0);
        chk(1, "lu_add_a", KA, 32'h4444);
        chk(1, "lu_add_b", KB, 32'h10);
        chk(1, "lu_add_alu", KAlu, 0);
        chk(1, "lu_add_dest", KDest, 5);
        step();
`endif

        // sub in ID with flush and hold together: flush wins
        drive_id(1, 6'h00, 6'h22, 1, 2, 6, 32'h1, 32'h2, 16'h0000);
        flush = 1'b1;
        ex_hold = 1'b1;
        chk(0, "fh_stall", KStall, 1);
        chk(1, "fh_valid", KValid, 0);
        chk(1, "fh_alu", KAlu, 7);
        chk(1, "fh_a", KA, 0);
        step();

        // add $0,$1,$2: no register write
        flush = 1'b0;
        ex_hold = 1'b0;
        set_mem(0, 0, 0, 0);
        drive_id(1, 6'h00, 6'h20, 1, 2, 0, 32'd3, 32'd4, 16'h0000);
        chk(0, "r0_stall", KStall, 0);
        chk(1, "r0_valid", KValid, 1);
        chk(1, "r0_rw", KRw, 0);
        chk(1, "r0_a", KA, 3);
        chk(1, "r0_b", KB, 4);
        step();

        // hold freezes EX while ID changes
        ex_hold = 1'b1;
        drive_id(1, 6'h00, 6'h26, 1, 2, 9, 32'd7, 32'd7, 16'h0000);
        chk(0, "hold_stall", KStall, 1);
        chk(1, "hold_alu", KAlu, 0);
        chk(1, "hold_a", KA, 3);
        chk(1, "hold_b", KB, 4);
        step();

        // sw $7,4($6) with $7 retiring in WB
        ex_hold = 1'b0;
        set_wb(1, 1, 7, 32'h1234);
        drive_id(1, 6'h2B, 0, 6, 7, 0, 32'h2000, 32'h1, 16'h0004);
        chk(0, "sw_stall", KStall, 0);
        chk(1, "sw_mw", KMw, 1);
        chk(1, "sw_rw", KRw, 0);
        chk(1, "sw_a", KA, 32'h2000);
        chk(1, "sw_b", KB, 4);
`ifdef ID_EX_FORWARD_EN
        chk(1, "sw_sd", KSd, 32'h1234);
`else
        chk(1, "sw_sd", KSd, 32'h1);
`endif
        step();

        // beq $8,$9: b comes from rt
        drive_id(1, 6'h04, 0, 8, 9, 0, 32'd5, 32'd6, 16'h0003);
        chk(0, "beq_stall", KStall, 0);
        chk(1, "beq_alu", KAlu, 1);
        chk(1, "beq_br", KBr, 1);
        chk(1, "beq_a", KA, 5);
        chk(1, "beq_b", KB, 6);
        chk(1, "beq_rw", KRw, 0);
        step();

        // unsupported opcode
        set_wb(0, 0, 0, 0);
        drive_id(1, 6'h3F, 0, 0, 0, 0, 0, 0, 16'h0000);
        chk(1, "unk_valid", KValid, 1);
        chk(1, "unk_alu", KAlu, 7);
        chk(1, "unk_rw", KRw, 0);
        step();

        // slti $3,$0,0x8000 sign-extends; andi $3,$0,0x8000 zero-extends
        drive_id(1, 6'h0A, 0, 0, 3, 0, 0, 0, 16'h8000);
        chk(1, "slti_alu", KAlu, 6);
        chk(1, "slti_b", KB, 32'hFFFF8000);
        step();
        drive_id(1, 6'h0C, 0, 0, 3, 0, 0, 0, 16'h8000);
        chk(1, "andi_alu", KAlu, 2);
        chk(1, "andi_b", KB, 32'h00008000);
        step();

        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL expired_wait: %0d expectations never compared", sb.size());
            foreach (sb[i]) $display("FAIL pending %s (due cycle %0d)", sb[i].name, sb[i].cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
